// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset/exception vectors, NOP encoding,
// fetch-state enumeration and a PC alignment helper.
package mips_defs;

  localparam logic [31:0] RESET_PC_DEF  = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_BEV1  = 32'hBFC0_0380;
  localparam logic [31:0] EXC_VEC_BEV0  = 32'h8000_0180;

  typedef enum logic [1:0] {
    F_REQ,
    F_WAIT,
    F_HOLD
  } fetch_state_e;

  function automatic logic misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clear-to-bubble has priority over load;
// with neither, contents are held (decode stall).
module if_id_reg
  import mips_defs::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_pc,
  input  logic [31:0] next_pc_plus4,
  input  logic        next_adel,
  input  logic        next_in_ds,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        valid,
  output logic        adel,
  output logic        in_ds
);

  // Bubble insertion, instruction load, or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
      adel     <= 1'b0;
      in_ds    <= 1'b0;
    end else if (clr) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
      adel  <= 1'b0;
      in_ds <= 1'b0;
    end else if (load) begin
      instr    <= next_instr;
      pc       <= next_pc;
      pc_plus4 <= next_pc_plus4;
      valid    <= 1'b1;
      adel     <= next_adel;
      in_ds    <= next_in_ds;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns pcF, runs the single-outstanding sram-like
// instruction bus, handles delayed-branch redirect, exception restart and
// misaligned-PC faults, and feeds the IF/ID register.
module fetch_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        is_branchD,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc_flush,
  input  logic [31:0] exc_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pc_plus4D,
  output logic        validD,
  output logic        adelD,
  output logic        in_dsD
);

  fetch_state_e state, state_n;
  logic [31:0]  pc_f, pc_f_n;
  logic         discard, discard_n;
  logic         redir_pend, redir_pend_n;
  logic [31:0]  redir_pc, redir_pc_n;
  logic         lock, lock_n;
  logic [31:0]  lock_addr, lock_addr_n;
  logic [31:0]  hold_instr, hold_instr_n;
  logic         last_br, last_br_n;

  logic         fault, avail, handoff, redir_now, d_clr;
  logic [31:0]  next_pc, fetched;

  // Bus outputs: an exception during an unaccepted request keeps the old
  // address (lock) until the bus takes it, so the request never changes early.
  always_comb begin
    inst_addr = lock ? lock_addr : pc_f;
    inst_req  = ~rst & (state == F_REQ) & (lock | ~misaligned(pc_f));
  end

  // Next-state, PC sequencing and hand-off decisions.
  always_comb begin
    state_n      = state;
    pc_f_n       = pc_f;
    discard_n    = discard;
    redir_pend_n = redir_pend;
    redir_pc_n   = redir_pc;
    lock_n       = lock;
    lock_addr_n  = lock_addr;
    hold_instr_n = hold_instr;
    last_br_n    = last_br;

    fault     = (state == F_REQ) & ~lock & misaligned(pc_f);
    avail     = ((state == F_WAIT) & inst_data_ok & ~discard) | (state == F_HOLD) | fault;
    handoff   = avail & ~stallD & ~flushD & ~exc_flush;
    redir_now = redirect & validD & ~stallD;
    d_clr     = exc_flush | flushD | (~stallD & ~avail);

    if (redir_pend)     next_pc = redir_pc;
    else if (redir_now) next_pc = redirect_pc;
    else                next_pc = pc_f + 32'd4;

    if (state == F_HOLD) fetched = hold_instr;
    else if (fault)      fetched = NOP_INSTR;
    else                 fetched = inst_rdata;

    if (exc_flush) begin
      pc_f_n       = exc_pc;
      redir_pend_n = 1'b0;
      last_br_n    = 1'b0;
      unique case (state)
        F_REQ: begin
          if (inst_req & inst_addr_ok) begin
            state_n   = F_WAIT;
            discard_n = 1'b1;
            lock_n    = 1'b0;
          end else if (inst_req & ~lock) begin
            lock_n      = 1'b1;
            lock_addr_n = pc_f;
          end
        end
        F_WAIT: begin
          if (inst_data_ok) begin
            state_n   = F_REQ;
            discard_n = 1'b0;
          end else begin
            discard_n = 1'b1;
          end
        end
        F_HOLD:  state_n = F_REQ;
        default: state_n = F_REQ;
      endcase
    end else begin
      if (redir_now) begin
        redir_pend_n = 1'b1;
        redir_pc_n   = redirect_pc;
      end
      // The branch may have left D as a bubble follows it, so remember
      // whether the last real instruction in D was a branch.
      if (validD & ~stallD) last_br_n = is_branchD;
      unique case (state)
        F_REQ: begin
          if (inst_req & inst_addr_ok) begin
            state_n = F_WAIT;
            if (lock) begin
              discard_n = 1'b1;
              lock_n    = 1'b0;
            end
          end
        end
        F_WAIT: begin
          if (inst_data_ok) begin
            if (discard) begin
              discard_n = 1'b0;
              state_n   = F_REQ;
            end else if (handoff) begin
              state_n = F_REQ;
            end else begin
              state_n      = F_HOLD;
              hold_instr_n = inst_rdata;
            end
          end
        end
        F_HOLD:  if (handoff) state_n = F_REQ;
        default: state_n = F_REQ;
      endcase
      if (handoff) begin
        pc_f_n       = next_pc;
        redir_pend_n = 1'b0;
      end
    end
  end

  // Fetch state and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= F_REQ;
      pc_f       <= RESET_PC;
      discard    <= 1'b0;
      redir_pend <= 1'b0;
      redir_pc   <= '0;
      lock       <= 1'b0;
      lock_addr  <= '0;
      hold_instr <= NOP_INSTR;
      last_br    <= 1'b0;
    end else begin
      state      <= state_n;
      pc_f       <= pc_f_n;
      discard    <= discard_n;
      redir_pend <= redir_pend_n;
      redir_pc   <= redir_pc_n;
      lock       <= lock_n;
      lock_addr  <= lock_addr_n;
      hold_instr <= hold_instr_n;
      last_br    <= last_br_n;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk          (clk),
    .rst          (rst),
    .clr          (d_clr),
    .load         (handoff),
    .next_instr   (fetched),
    .next_pc      (pc_f),
    .next_pc_plus4(pc_f + 32'd4),
    .next_adel    (fault),
    .next_in_ds   (validD ? is_branchD : last_br),
    .instr        (instrD),
    .pc           (pcD),
    .pc_plus4     (pc_plus4D),
    .valid        (validD),
    .adel         (adelD),
    .in_ds        (in_dsD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage plus hand-written sequences
// for flush-hold, reset mid-transaction and exception during a pending request.
module tb_fetch_stage;

  localparam logic [31:0] B = 32'hBFC0_0000;
  localparam logic [31:0] W = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallD, flushD, is_branchD, redirect, exc_flush;
  logic [31:0] redirect_pc, exc_pc;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic [31:0] instrD, pcD, pc_plus4D;
  logic        validD, adelD, in_dsD;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .RESET_PC (32'hBFC0_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallD      (stallD),
    .flushD      (flushD),
    .is_branchD  (is_branchD),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .exc_flush   (exc_flush),
    .exc_pc      (exc_pc),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .instrD      (instrD),
    .pcD         (pcD),
    .pc_plus4D   (pc_plus4D),
    .validD      (validD),
    .adelD       (adelD),
    .in_dsD      (in_dsD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, flush, br, redir;
    logic [31:0] rpc;
    logic        exc;
    logic [31:0] epc;
    logic        aok, dok;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pcd, ins;
    logic        adel, ds;
  } vec_t;

  function automatic vec_t mk(
    input logic stall, flush, br, redir, input logic [31:0] rpc,
    input logic exc, input logic [31:0] epc, input logic aok, dok,
    input logic [31:0] rd, input logic req, input logic [31:0] addr,
    input logic valid, input logic [31:0] pcd, ins, input logic adel, ds);
    vec_t v;
    v.stall = stall; v.flush = flush; v.br = br; v.redir = redir; v.rpc = rpc;
    v.exc = exc; v.epc = epc; v.aok = aok; v.dok = dok; v.rd = rd;
    v.req = req; v.addr = addr; v.valid = valid; v.pcd = pcd; v.ins = ins;
    v.adel = adel; v.ds = ds;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic stall, flush, br, redir, input logic [31:0] rpc,
                       input logic exc, input logic [31:0] epc, input logic aok, dok,
                       input logic [31:0] rd);
    stallD = stall; flushD = flush; is_branchD = br; redirect = redir;
    redirect_pc = rpc; exc_flush = exc; exc_pc = epc;
    inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, '0, 0, '0, 0, 0, '0);
  endtask

  vec_t vecs[27];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // cycle-by-cycle: stall flush br redir rpc exc epc aok dok rd | req addr valid pcD instrD adel ds
    vecs[0]  = mk(0,0,0,0,'0,0,'0,1,0,'0,          1,B,        0,'0,'0,0,0);
    vecs[1]  = mk(0,0,0,0,'0,0,'0,0,1,W,           0,'0,       0,'0,'0,0,0);
    vecs[2]  = mk(0,0,0,0,'0,0,'0,1,0,'0,          1,B+4,      1,B,W,0,0);
    vecs[3]  = mk(0,0,0,0,'0,0,'0,0,1,W+4,         0,'0,       0,'0,'0,0,0);
    vecs[4]  = mk(0,0,0,0,'0,0,'0,1,0,'0,          1,B+8,      1,B+4,W+4,0,0);
    vecs[5]  = mk(0,0,0,0,'0,0,'0,0,1,W+8,         0,'0,       0,'0,'0,0,0);
    vecs[6]  = mk(0,0,1,1,B+'h100,0,'0,1,0,'0,     1,B+'hC,    1,B+8,W+8,0,0);
    vecs[7]  = mk(0,0,0,0,'0,0,'0,0,1,W+'hC,       0,'0,       0,'0,'0,0,0);
    vecs[8]  = mk(0,0,0,0,'0,0,'0,1,0,'0,          1,B+'h100,  1,B+'hC,W+'hC,0,1);
    vecs[9]  = mk(0,0,0,0,'0,0,'0,0,1,W+'h100,     0,'0,       0,'0,'0,0,0);
    vecs[10] = mk(0,0,0,0,'0,0,'0,0,0,'0,          1,B+'h104,  1,B+'h100,W+'h100,0,0);
    vecs[11] = mk(0,0,0,0,'0,0,'0,1,0,'0,          1,B+'h104,  0,'0,'0,0,0);
    vecs[12] = mk(0,0,0,0,'0,1,B+'h380,0,0,'0,     0,'0,       0,'0,'0,0,0);
    vecs[13] = mk(0,0,0,0,'0,0,'0,0,1,32'hDEADBEEF,0,'0,       0,'0,'0,0,0);
    vecs[14] = mk(0,0,0,0,'0,0,'0,1,0,'0,          1,B+'h380,  0,'0,'0,0,0);
    vecs[15] = mk(0,0,0,0,'0,0,'0,0,1,W+'h380,     0,'0,       0,'0,'0,0,0);
    vecs[16] = mk(1,0,0,0,'0,0,'0,1,0,'0,          1,B+'h384,  1,B+'h380,W+'h380,0,0);
    vecs[17] = mk(1,0,0,0,'0,0,'0,0,1,W+'h384,     0,'0,       1,B+'h380,W+'h380,0,0);
    vecs[18] = mk(1,0,0,0,'0,0,'0,0,0,'0,          0,'0,       1,B+'h380,W+'h380,0,0);
    vecs[19] = mk(0,0,0,0,'0,0,'0,0,0,'0,          0,'0,       1,B+'h380,W+'h380,0,0);
    vecs[20] = mk(0,0,0,0,'0,0,'0,1,0,'0,          1,B+'h388,  1,B+'h384,W+'h384,0,0);
    vecs[21] = mk(0,0,0,0,'0,0,'0,0,1,W+'h388,     0,'0,       0,'0,'0,0,0);
    vecs[22] = mk(0,0,1,1,B+'h102,0,'0,1,0,'0,     1,B+'h38C,  1,B+'h388,W+'h388,0,0);
    vecs[23] = mk(0,0,0,0,'0,0,'0,0,1,W+'h38C,     0,'0,       0,'0,'0,0,0);
    vecs[24] = mk(0,0,0,0,'0,0,'0,0,0,'0,          0,'0,       1,B+'h38C,W+'h38C,0,1);
    vecs[25] = mk(0,0,0,0,'0,1,B+'h380,0,0,'0,     0,'0,       1,B+'h102,'0,1,0);
    vecs[26] = mk(0,0,0,0,'0,0,'0,0,0,'0,          1,B+'h380,  0,'0,'0,0,0);

    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, inst_req}, 32'd0);
    chk("rst_validD", {31'd0, validD}, 32'd0);
    chk("rst_instrD", instrD, 32'd0);
    chk("rst_pcD", pcD, 32'd0);
    chk("rst_pc_plus4D", pc_plus4D, 32'd0);
    chk("rst_adelD", {31'd0, adelD}, 32'd0);
    chk("rst_in_dsD", {31'd0, in_dsD}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      drive(vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].redir, vecs[i].rpc,
            vecs[i].exc, vecs[i].epc, vecs[i].aok, vecs[i].dok, vecs[i].rd);
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, inst_req}, {31'd0, vecs[i].req});
      if (vecs[i].req) chk($sformatf("v%0d_addr", i), inst_addr, vecs[i].addr);
      chk($sformatf("v%0d_validD", i), {31'd0, validD}, {31'd0, vecs[i].valid});
      chk($sformatf("v%0d_adelD", i), {31'd0, adelD}, {31'd0, vecs[i].adel});
      chk($sformatf("v%0d_in_dsD", i), {31'd0, in_dsD}, {31'd0, vecs[i].ds});
      chk($sformatf("v%0d_instrD", i), instrD, vecs[i].ins);
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_pcD", i), pcD, vecs[i].pcd);
        chk($sformatf("v%0d_pc_plus4D", i), pc_plus4D, vecs[i].pcd + 32'd4);
      end
    end

    // flushD with data arriving: word is held and handed off once flush drops
    @(negedge clk); idle(); inst_addr_ok = 1'b1;
    @(negedge clk); idle(); inst_data_ok = 1'b1; flushD = 1'b1; inst_rdata = 32'h1111_1111;
    @(negedge clk); idle(); #1;
    chk("fl_hold_req", {31'd0, inst_req}, 32'd0);
    chk("fl_validD", {31'd0, validD}, 32'd0);
    @(negedge clk); #1;
    chk("fl_out_validD", {31'd0, validD}, 32'd1);
    chk("fl_out_instrD", instrD, 32'h1111_1111);
    chk("fl_out_pcD", pcD, B + 32'h380);
    chk("fl_next_req", {31'd0, inst_req}, 32'd1);
    chk("fl_next_addr", inst_addr, B + 32'h384);

    // reset while waiting for data; late data_ok must be ignored
    inst_addr_ok = 1'b1;
    @(negedge clk); idle(); rst = 1'b1; #1;
    chk("mr_req", {31'd0, inst_req}, 32'd0);
    chk("mr_validD", {31'd0, validD}, 32'd0);
    chk("mr_pcD", pcD, 32'd0);
    chk("mr_instrD", instrD, 32'd0);
    @(negedge clk); inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_0001;
    @(negedge clk); rst = 1'b0; #1;
    chk("mr_first_req", {31'd0, inst_req}, 32'd1);
    chk("mr_first_addr", inst_addr, B);
    @(negedge clk); idle(); #1;
    chk("mr_late_req", {31'd0, inst_req}, 32'd1);
    chk("mr_late_addr", inst_addr, B);
    chk("mr_late_validD", {31'd0, validD}, 32'd0);

    // exception while request not yet accepted: old address held, then drained
    exc_flush = 1'b1; exc_pc = B + 32'h380;
    @(negedge clk); idle(); #1;
    chk("ex_hold_req", {31'd0, inst_req}, 32'd1);
    chk("ex_hold_addr", inst_addr, B);
    inst_addr_ok = 1'b1;
    @(negedge clk); idle(); inst_data_ok = 1'b1; inst_rdata = 32'h0BAD_C0DE; #1;
    chk("ex_wait_req", {31'd0, inst_req}, 32'd0);
    @(negedge clk); idle(); #1;
    chk("ex_new_req", {31'd0, inst_req}, 32'd1);
    chk("ex_new_addr", inst_addr, B + 32'h380);
    chk("ex_drop_validD", {31'd0, validD}, 32'd0);
    inst_addr_ok = 1'b1;
    @(negedge clk); idle(); inst_data_ok = 1'b1; inst_rdata = W + 32'h380;
    @(negedge clk); idle(); #1;
    chk("ex_ret_validD", {31'd0, validD}, 32'd1);
    chk("ex_ret_pcD", pcD, B + 32'h380);
    chk("ex_ret_instrD", instrD, W + 32'h380);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
